// File: rtl/komandara_k10_pkg.sv
// ============================================================================
// Module   : komandara_k10_pkg
// Brief    : Shared K10 core types: privilege levels and PMP arbiter encodings
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package komandara_k10_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK0 = 2'd1,
    CHECK1 = 2'd2,
    RESP   = 2'd3
  } pmp_arb_state_e;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSU = 1'b1
  } pmp_req_src_e;

  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

endpackage

`default_nettype wire

// File: rtl/k10_pmp_arb.sv
// ============================================================================
// Module   : k10_pmp_arb
// Brief    : Round-robin sequencer sharing one PMP checker between IF and LSU.
//            Define K10_PMP_SPLIT_EN to also check the last byte of misaligned
//            accesses and deny accesses wrapping past the top of memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module k10_pmp_arb
  import komandara_k10_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  priv_lvl_e   i_if_priv,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic        o_if_allowed,
  input  logic        i_lsu_req,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_we,
  input  logic [1:0]  i_lsu_size,
  input  priv_lvl_e   i_lsu_priv,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic        o_lsu_allowed,
  input  logic        i_pmp_cfg_wr,
  output logic [31:0] o_pmp_addr,
  output priv_lvl_e   o_pmp_priv,
  output logic        o_pmp_read,
  output logic        o_pmp_write,
  output logic        o_pmp_exec,
  input  logic        i_pmp_allowed
);

  pmp_arb_state_e state_q, state_d;
  pmp_req_src_e   last_q, last_d;
  pmp_req_src_e   src_q, src_d;
  logic [31:0]    addr_q, addr_d;
  priv_lvl_e      priv_q, priv_d;
  logic           we_q, we_d;
  logic [1:0]     size_q, size_d;
  logic           ok_q, ok_d;
  logic [31:0]    pmp_addr_q, pmp_addr_d;
  priv_lvl_e      pmp_priv_q, pmp_priv_d;

  logic gnt_if, gnt_lsu;
  logic illegal_size;
  logic need_check1;
  logic force_deny;

  assign illegal_size = (size_q == SIZE_ILLEGAL);

`ifdef K10_PMP_SPLIT_EN
  logic [32:0] end_sum;

  // Carry out of bit 31 means the access wraps past 0xFFFFFFFF.
  assign end_sum     = {1'b0, addr_q} + (33'd1 << size_q) - 33'd1;
  assign force_deny  = end_sum[32];
  assign need_check1 = ((size_q == 2'd1) && (addr_q[1:0] == 2'b11)) ||
                       ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign force_deny  = 1'b0;
  assign need_check1 = 1'b0;
`endif

  // Ties go to whichever requester was not served last.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_lsu = 1'b0;
    if ((state_q == IDLE) && !i_rst) begin
      gnt_if  = i_if_req && (!i_lsu_req || (last_q == SRC_LSU));
      gnt_lsu = i_lsu_req && !gnt_if;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_q     <= SRC_LSU;
      src_q      <= SRC_IF;
      addr_q     <= 32'd0;
      priv_q     <= PRIV_M;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      ok_q       <= 1'b0;
      pmp_addr_q <= 32'd0;
      pmp_priv_q <= PRIV_M;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      src_q      <= src_d;
      addr_q     <= addr_d;
      priv_q     <= priv_d;
      we_q       <= we_d;
      size_q     <= size_d;
      ok_q       <= ok_d;
      pmp_addr_q <= pmp_addr_d;
      pmp_priv_q <= pmp_priv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    addr_d  = addr_q;
    priv_d  = priv_q;
    we_d    = we_q;
    size_d  = size_q;
    ok_d    = ok_q;
    case (state_q)
      IDLE: begin
        if (gnt_if) begin
          state_d = CHECK0;
          src_d   = SRC_IF;
          last_d  = SRC_IF;
          addr_d  = i_if_addr;
          priv_d  = i_if_priv;
          we_d    = 1'b0;
          size_d  = SIZE_WORD;
        end else if (gnt_lsu) begin
          state_d = CHECK0;
          src_d   = SRC_LSU;
          last_d  = SRC_LSU;
          addr_d  = i_lsu_addr;
          priv_d  = i_lsu_priv;
          we_d    = i_lsu_we;
          size_d  = i_lsu_size;
        end
      end
      CHECK0: begin
        if (i_pmp_cfg_wr) begin
          state_d = CHECK0;
          ok_d    = 1'b0;
        end else if (illegal_size || force_deny) begin
          state_d = RESP;
          ok_d    = 1'b0;
        end else begin
          state_d = need_check1 ? CHECK1 : RESP;
          ok_d    = i_pmp_allowed;
        end
      end
`ifdef K10_PMP_SPLIT_EN
      CHECK1: begin
        if (i_pmp_cfg_wr) begin
          state_d = CHECK0;
          ok_d    = 1'b0;
        end else begin
          state_d = RESP;
          ok_d    = ok_q & i_pmp_allowed;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_if_gnt      = gnt_if;
    o_lsu_gnt     = gnt_lsu;
    o_if_rvalid   = (state_q == RESP) && !i_rst && (src_q == SRC_IF);
    o_lsu_rvalid  = (state_q == RESP) && !i_rst && (src_q == SRC_LSU);
    o_if_allowed  = o_if_rvalid && ok_q;
    o_lsu_allowed = o_lsu_rvalid && ok_q;
    o_pmp_addr    = pmp_addr_q;
    o_pmp_priv    = pmp_priv_q;
    o_pmp_read    = 1'b0;
    o_pmp_write   = 1'b0;
    o_pmp_exec    = 1'b0;
    case (state_q)
      CHECK0: begin
        o_pmp_addr  = addr_q;
        o_pmp_priv  = priv_q;
        o_pmp_read  = (src_q == SRC_LSU) && !we_q;
        o_pmp_write = (src_q == SRC_LSU) && we_q;
        o_pmp_exec  = (src_q == SRC_IF);
      end
`ifdef K10_PMP_SPLIT_EN
      CHECK1: begin
        o_pmp_addr  = end_sum[31:0];
        o_pmp_priv  = priv_q;
        o_pmp_read  = (src_q == SRC_LSU) && !we_q;
        o_pmp_write = (src_q == SRC_LSU) && we_q;
        o_pmp_exec  = (src_q == SRC_IF);
      end
`endif
      default: begin
      end
    endcase
    // Checker address/privilege stay parked on the last checked values.
    pmp_addr_d = o_pmp_addr;
    pmp_priv_d = o_pmp_priv;
  end

endmodule

`default_nettype wire
